keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Input-side counterpart of the 7-seg display peripheral on the Minisys-1A I/O bus.
//  Scans a 4x4 matrix keypad, debounces, and latches a 4-bit key code.
//  The CPU reads the key code and status over the same chip-select/address/enable bus.
//  Everything is clocked on posedge clock.
// PARAMETERS
//  SCAN_DIV        50000  clocks per scan tick, >=2 (one column slot)
//  DEBOUNCE_TICKS  10     consecutive identical row samples required on press and on release
// PORTS
//  clock           in   1   system clock; the only clock
//  reset           in   1   asynchronous, active-high
//  keyboardCtrl    in   1   chip select from address decoder
//  read_enable     in   1   CPU read strobe
//  address         in   3   3'b000 = KEY data, 3'b010 = STATUS; others read 0
//  read_data_out   out  16  read data; 0 when not selected
//  col             out  4   column drive, active-low, one-hot-low
//  row             in   4   row sense, active-low, externally pulled up, asynchronous
// BEHAVIOUR
//  Reset values
//   - state=SCAN, col=4'b1110, tick counter=0, debounce counter=0.
//   - key_reg=0, valid=0, overrun=0, read_data_out=0.
//  Input sync: row passes a 2-flop synchronizer (rs); all decisions use rs.
//  Tick: a counter wraps at SCAN_DIV-1; tick=1 for one clock at the wrap.
//   All FSM sampling happens only on tick clocks.
//  SCAN
//   - On tick with rs==4'hF: rotate col left (1110->1101->1011->0111->1110).
//   - On tick with rs!=4'hF: r = lowest index with rs[r]==0, c = driven column.
//     Capture pat=rs, hold col, deb=0, go DEBOUNCE.
//  DEBOUNCE (col held)
//   - Tick with rs==pat: deb++.
//   - When deb reaches DEBOUNCE_TICKS: key_reg[3:0]={r[1:0],c[1:0]}, i.e. code=4*r+c.
//     Also: overrun|=valid, valid=1, go RELEASE.
//   - Tick with rs!=pat: go SCAN and resume rotating from the same col. Nothing is latched.
//  RELEASE (col held)
//   - Needs DEBOUNCE_TICKS consecutive ticks with rs==4'hF, then go SCAN.
//   - Any tick with rs!=4'hF restarts that count. No second latch while held.
//  Press-to-valid latency: DEBOUNCE_TICKS+1 ticks after the first tick that sees the key,
//   plus 2 clocks of synchronizer delay.
//  Bus
//   - read_data_out is combinational and nonzero only when keyboardCtrl & read_enable.
//   - KEY    = {12'b0, key_reg[3:0]}.
//   - STATUS = {13'b0, overrun, held, valid}; held=1 when state!=SCAN.
//  Read side effects (on clock edges with keyboardCtrl & read_enable)
//   - KEY read clears valid.
//   - STATUS read clears overrun.
//   - A latch in the same clock as a clearing read wins: the flag stays 1, key_reg updates.
//   - Reads never stall or alter the scan.
//  Multiple rows low: the lowest row index wins. Multi-column ghosting is not resolved.
//  Reset mid-operation: immediate return to the reset values, scan restarts at column 0.
// STRUCTURE
//  Shared header minisys_io_defs:
//   - KEY_ADDR_DATA=3'b000, KEY_ADDR_STATUS=3'b010.
//   - Status bit indices VALID=0, HELD=1, OVERRUN=2.
//   - FSM state encodings SCAN/DEBOUNCE/RELEASE.
//  Sub-module keypad_scan_tick:
//   - Prescaler producing tick. Parameter SCAN_DIV, ports clock, reset, tick.
//  The FSM, synchronizer and bus registers stay in keypad_scanner.
// TESTING (bench: SCAN_DIV=4, DEBOUNCE_TICKS=3, keypad model drives row from col)
//  1 Reset then idle 40 clocks
//    -> col cycles E,D,B,7,E every 4 clocks.
//    -> STATUS read = 16'h0000, KEY read = 16'h0000.
//  2 Hold key r=2,c=1 for 100 clocks, release
//    -> col frozen at 4'b1101, valid set 16 clocks after detection.
//    -> KEY=16'h0009, STATUS=16'h0003 while held, 16'h0002 after KEY read.
//    -> After release plus 3 clean ticks: STATUS=16'h0000, rotation resumes.
//  3 Bounce: key r=0,c=3 pulses low 1 tick, high 1 tick, repeated
//    -> valid never set, FSM returns to SCAN.
//    -> Then a stable press gives KEY=16'h0003.
//  4 Two full presses (r1c0, then r3c3) without a KEY read
//    -> STATUS=16'h0005 after the second, KEY=16'h000F.
//    -> STATUS read clears overrun: next STATUS=16'h0001.
//  5 KEY read issued on the exact clock valid is latched
//    -> valid remains 1, key_reg holds the new code.
//  6 Assert reset during DEBOUNCE and during RELEASE
//    -> col=4'b1110, all flags 0 asynchronously.
//    -> keyboardCtrl=0 or address=3'b100 reads 16'h0000.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared I/O definitions for the Minisys keypad scanner: bus addresses,
// status bit positions, FSM states and a row/column index helper.
package keypad_scanner_pkg;

    localparam logic [2:0] KEY_ADDR_DATA   = 3'b000;
    localparam logic [2:0] KEY_ADDR_STATUS = 3'b010;

    localparam int STAT_VALID   = 0;
    localparam int STAT_HELD    = 1;
    localparam int STAT_OVERRUN = 2;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_RELEASE  = 2'd2
    } kp_state_e;

    // Index of the lowest active-low bit; works for both row patterns and the one-hot-low column drive.
    function automatic logic [1:0] lowest_low_index(input logic [3:0] v);
        if (!v[0])      return 2'd0;
        else if (!v[1]) return 2'd1;
        else if (!v[2]) return 2'd2;
        else            return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Scan prescaler: emits a one-clock tick every SCAN_DIV clocks.
module keypad_scan_tick #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce, latched key code and CPU bus
// read port (KEY / STATUS) with read-to-clear flags.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        keyboardCtrl,
    input  logic        read_enable,
    input  logic [2:0]  address,
    output logic [15:0] read_data_out,
    output logic [3:0]  col,
    input  logic [3:0]  row
);

    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] DEB_DONE = DW'(DEBOUNCE_TICKS);
    localparam logic [DW-1:0] REL_DONE = DW'(DEBOUNCE_TICKS - 1);

    logic            tick;
    logic [3:0]      rs_meta_q, rs_q;
    kp_state_e       state_q, state_d;
    logic [3:0]      col_q, col_d;
    logic [3:0]      pat_q, pat_d;
    logic [3:0]      key_q, key_d;
    logic [1:0]      row_idx_q, row_idx_d;
    logic [DW-1:0]   deb_q, deb_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;
    logic            latch, bus_rd, clr_valid, clr_overrun, held;
    logic [2:0]      status;

    keypad_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // Rows are asynchronous to the clock; every decision below uses rs_q only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rs_meta_q <= 4'hF;
            rs_q      <= 4'hF;
        end else begin
            rs_meta_q <= row;
            rs_q      <= rs_meta_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_SCAN;
            col_q     <= 4'b1110;
            pat_q     <= 4'hF;
            row_idx_q <= 2'd0;
            deb_q     <= '0;
            key_q     <= 4'h0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            pat_q     <= pat_d;
            row_idx_q <= row_idx_d;
            deb_q     <= deb_d;
            key_q     <= key_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        pat_d     = pat_q;
        row_idx_d = row_idx_q;
        deb_d     = deb_q;
        key_d     = key_q;
        latch     = 1'b0;

        case (state_q)
            ST_SCAN: begin
                if (tick) begin
                    if (rs_q == 4'hF) begin
                        col_d = {col_q[2:0], col_q[3]};
                    end else begin
                        pat_d     = rs_q;
                        row_idx_d = lowest_low_index(rs_q);
                        deb_d     = '0;
                        state_d   = ST_DEBOUNCE;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (rs_q != pat_q) begin
                        deb_d   = '0;
                        state_d = ST_SCAN;
                    end else if (deb_q == DEB_DONE) begin
                        latch   = 1'b1;
                        key_d   = {row_idx_q, lowest_low_index(col_q)};
                        deb_d   = '0;
                        state_d = ST_RELEASE;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                if (tick) begin
                    if (rs_q != 4'hF) begin
                        deb_d = '0;
                    end else if (deb_q == REL_DONE) begin
                        deb_d   = '0;
                        state_d = ST_SCAN;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end
            end
            default: begin
                deb_d   = '0;
                state_d = ST_SCAN;
            end
        endcase

        // A latch in the same clock as a clearing read keeps the flag set.
        bus_rd      = keyboardCtrl & read_enable;
        clr_valid   = bus_rd && (address == KEY_ADDR_DATA);
        clr_overrun = bus_rd && (address == KEY_ADDR_STATUS);
        valid_d     = latch | (valid_q & ~clr_valid);
        overrun_d   = latch ? (overrun_q | valid_q) : (overrun_q & ~clr_overrun);
    end

    always_comb begin
        held                 = (state_q != ST_SCAN);
        col                  = col_q;
        status               = 3'b000;
        status[STAT_VALID]   = valid_q;
        status[STAT_HELD]    = held;
        status[STAT_OVERRUN] = overrun_q;
        read_data_out        = 16'h0000;
        if (keyboardCtrl && read_enable) begin
            case (address)
                KEY_ADDR_DATA:   read_data_out = {12'h000, key_q};
                KEY_ADDR_STATUS: read_data_out = {13'h0000, status};
                default:         read_data_out = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a behavioural keypad drives row from col,
// expectations come from the key-code/flag rules computed in the bench.
module tb_keypad_scanner;

    localparam int DIV = 4;
    localparam int DT  = 3;
    localparam logic [2:0] A_KEY  = 3'b000;
    localparam logic [2:0] A_STAT = 3'b010;

    logic        clock = 1'b0;
    logic        reset;
    logic        keyboardCtrl;
    logic        read_enable;
    logic [2:0]  address;
    logic [15:0] read_data_out;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] pressed;   // bit 4*r+c set = key (r,c) closed

    int tests = 0;
    int fails = 0;

    keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_TICKS(DT)) dut (
        .clock         (clock),
        .reset         (reset),
        .keyboardCtrl  (keyboardCtrl),
        .read_enable   (read_enable),
        .address       (address),
        .read_data_out (read_data_out),
        .col           (col),
        .row           (row)
    );

    always #5 clock = ~clock;

    // Matrix model: a row is pulled low when any closed key on it sits in a driven column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[4*r+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clock);
        keyboardCtrl = 1'b1; read_enable = 1'b1; address = a;
        #1 d = read_data_out;
        @(negedge clock);
        keyboardCtrl = 1'b0; read_enable = 1'b0; address = 3'b000;
    endtask

    task automatic check_read(input string name, input logic [2:0] a, input logic [15:0] exp);
        logic [15:0] d;
        bus_read(a, d);
        tests++;
        if (d !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, d, exp);
        end
    endtask

    task automatic press_release(input logic [15:0] m);
        @(negedge clock); pressed = m;
        repeat (60) @(negedge clock);
        pressed = 16'h0000;
        repeat (30) @(negedge clock);
    endtask

    task automatic apply_reset();
        @(negedge clock); reset = 1'b1; pressed = 16'h0000;
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        @(negedge clock);
        tests++;
        if (col !== 4'b1110) begin fails++; $display("FAIL reset_col: got %b expected 1110", col); end
        reset = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            exp_col = ~(4'b0001 << ((k / DIV) % 4));
            tests++;
            if (col !== exp_col) begin
                fails++;
                $display("FAIL idle_rotation k=%0d: got %b expected %b", k, col, exp_col);
            end
            @(negedge clock);
        end
        check_read("idle_status", A_STAT, 16'h0000);
        check_read("idle_key", A_KEY, 16'h0000);
    endtask

    task automatic test_hold();
        int th = -1, tv = -1, tr = -1;
        logic [15:0] st;
        @(negedge clock); pressed = 16'h0000; pressed[4*2+1] = 1'b1;
        keyboardCtrl = 1'b1; read_enable = 1'b1; address = A_STAT;
        for (int n = 0; n < 100 && tv < 0; n++) begin
            #1 st = read_data_out;
            if (st[1] && th < 0) th = n;
            if (st[0] && tv < 0) tv = n;
            @(negedge clock);
        end
        keyboardCtrl = 1'b0; read_enable = 1'b0;
        tests++;
        if (th < 0 || tv < 0 || (tv - th) != 4*(DT+1)) begin
            fails++;
            $display("FAIL hold_latency: got held@%0d valid@%0d expected gap %0d", th, tv, 4*(DT+1));
        end
        tests++;
        if (col !== 4'b1101) begin fails++; $display("FAIL hold_col: got %b expected 1101", col); end
        check_read("hold_status", A_STAT, 16'h0003);
        check_read("hold_key", A_KEY, 16'h0009);
        check_read("hold_status_after_key", A_STAT, 16'h0002);
        repeat (20) @(negedge clock);
        check_read("hold_no_relatch", A_STAT, 16'h0002);
        tests++;
        if (col !== 4'b1101) begin fails++; $display("FAIL hold_col_frozen: got %b expected 1101", col); end
        @(negedge clock); pressed = 16'h0000;
        keyboardCtrl = 1'b1; read_enable = 1'b1; address = A_STAT;
        for (int n = 0; n < 40 && tr < 0; n++) begin
            #1 st = read_data_out;
            if (!st[1]) tr = n;
            else @(negedge clock);
        end
        keyboardCtrl = 1'b0; read_enable = 1'b0;
        tests++;
        if (tr < 2 + 2*DIV + 1 || tr > 2 + 3*DIV) begin
            fails++;
            $display("FAIL release_time: got %0d clocks expected %0d..%0d", tr, 2 + 2*DIV + 1, 2 + 3*DIV);
        end
        check_read("release_status", A_STAT, 16'h0000);
        repeat (8) @(negedge clock);
        tests++;
        if (col === 4'b1101) begin fails++; $display("FAIL release_rotation: got %b expected rotation away from 1101", col); end
    endtask

    task automatic test_bounce();
        int seen_valid = 0;
        @(negedge clock); pressed = 16'h0000;
        keyboardCtrl = 1'b1; read_enable = 1'b1; address = A_STAT;
        for (int h = 0; h < 30; h++) begin
            pressed[3] = ~pressed[3];
            for (int k = 0; k < DIV; k++) begin
                #1 if (read_data_out[0]) seen_valid++;
                @(negedge clock);
            end
        end
        keyboardCtrl = 1'b0; read_enable = 1'b0; pressed = 16'h0000;
        tests++;
        if (seen_valid != 0) begin fails++; $display("FAIL bounce_valid: got %0d valid samples expected 0", seen_valid); end
        repeat (30) @(negedge clock);
        check_read("bounce_idle_status", A_STAT, 16'h0000);
        press_release(16'h0008);
        check_read("bounce_stable_key", A_KEY, 16'h0003);
        check_read("bounce_after_read", A_STAT, 16'h0000);
    endtask

    task automatic test_overrun();
        press_release(16'h0010);
        press_release(16'h8000);
        check_read("overrun_status", A_STAT, 16'h0005);
        check_read("overrun_cleared", A_STAT, 16'h0001);
        check_read("overrun_key", A_KEY, 16'h000F);
        check_read("overrun_final", A_STAT, 16'h0000);
    endtask

    task automatic test_read_on_latch();
        int n0 = -1;
        logic [15:0] d;
        @(negedge clock); pressed = 16'h0040;
        keyboardCtrl = 1'b1; read_enable = 1'b1; address = A_STAT;
        for (int n = 0; n < 60 && n0 < 0; n++) begin
            #1 if (read_data_out[1]) n0 = n;
            else @(negedge clock);
        end
        tests++;
        if (n0 < 0) begin
            fails++;
            $display("FAIL latch_detect: got no held within 60 clocks expected held");
        end else begin
            repeat (4*(DT+1) - 1) @(negedge clock);
            address = A_KEY;
            #1 d = read_data_out;
            tests++;
            if (d !== 16'h000F) begin fails++; $display("FAIL latch_key_old: got %h expected 000f", d); end
            @(negedge clock);
            address = A_STAT;
            #1 d = read_data_out;
            tests++;
            if (d !== 16'h0003) begin fails++; $display("FAIL latch_valid_kept: got %h expected 0003", d); end
        end
        @(negedge clock);
        keyboardCtrl = 1'b0; read_enable = 1'b0;
        check_read("latch_key_new", A_KEY, 16'h0006);
        @(negedge clock); pressed = 16'h0000;
        repeat (30) @(negedge clock);
    endtask

    task automatic test_random();
        logic        exp_valid = 1'b0, exp_ovr = 1'b0;
        logic [3:0]  exp_code = 4'h0;
        logic [15:0] m;
        int r, r2, c, act;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            r  = $urandom_range(0, 3);
            c  = $urandom_range(0, 3);
            r2 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : r;
            m  = 16'h0000;
            m[4*r+c]  = 1'b1;
            m[4*r2+c] = 1'b1;
            press_release(m);
            exp_ovr   = exp_ovr | exp_valid;
            exp_valid = 1'b1;
            exp_code  = 4'((4 * ((r < r2) ? r : r2)) + c);
            act = $urandom_range(0, 2);
            if (act == 0) begin
                check_read("rand_status", A_STAT, {13'h0000, exp_ovr, 1'b0, exp_valid});
                exp_ovr = 1'b0;
            end else if (act == 1) begin
                check_read("rand_key", A_KEY, {12'h000, exp_code});
                exp_valid = 1'b0;
            end
        end
        check_read("rand_final_status", A_STAT, {13'h0000, exp_ovr, 1'b0, exp_valid});
        check_read("rand_final_key", A_KEY, {12'h000, exp_code});
    endtask

    task automatic reset_checks(input string tag);
        keyboardCtrl = 1'b1; read_enable = 1'b1; address = A_STAT;
        #1;
        tests++;
        if (col !== 4'b1110) begin fails++; $display("FAIL %s_col: got %b expected 1110", tag, col); end
        tests++;
        if (read_data_out !== 16'h0000) begin fails++; $display("FAIL %s_status: got %h expected 0000", tag, read_data_out); end
        address = A_KEY;
        #1;
        tests++;
        if (read_data_out !== 16'h0000) begin fails++; $display("FAIL %s_key: got %h expected 0000", tag, read_data_out); end
        keyboardCtrl = 1'b0; read_enable = 1'b0; address = 3'b000;
        pressed = 16'h0000;
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n0 = -1;
        @(negedge clock); pressed = 16'h0400;
        keyboardCtrl = 1'b1; read_enable = 1'b1; address = A_STAT;
        for (int n = 0; n < 60 && n0 < 0; n++) begin
            #1 if (read_data_out[1]) n0 = n;
            else @(negedge clock);
        end
        keyboardCtrl = 1'b0; read_enable = 1'b0;
        tests++;
        if (n0 < 0 || col !== 4'b1011) begin
            fails++;
            $display("FAIL debounce_entry: got col %b held@%0d expected 1011 held", col, n0);
        end
        #2 reset = 1'b1;
        reset_checks("rst_debounce");

        @(negedge clock); pressed = 16'h0002;
        repeat (60) @(negedge clock);
        keyboardCtrl = 1'b1; read_enable = 1'b1; address = 3'b100;
        #1;
        tests++;
        if (read_data_out !== 16'h0000) begin fails++; $display("FAIL unmapped_addr: got %h expected 0000", read_data_out); end
        keyboardCtrl = 1'b0; address = A_KEY;
        #1;
        tests++;
        if (read_data_out !== 16'h0000) begin fails++; $display("FAIL not_selected: got %h expected 0000", read_data_out); end
        keyboardCtrl = 1'b1;
        #1;
        tests++;
        if (read_data_out !== 16'h0001 || col !== 4'b1101) begin
            fails++;
            $display("FAIL release_state: got key %h col %b expected 0001 1101", read_data_out, col);
        end
        #1 reset = 1'b1;
        reset_checks("rst_release");
        tests++;
        if (col !== 4'b1110) begin fails++; $display("FAIL post_reset_col: got %b expected 1110", col); end
    endtask

    initial begin
        reset = 1'b1;
        keyboardCtrl = 1'b0;
        read_enable = 1'b0;
        address = 3'b000;
        pressed = 16'h0000;
        test_reset();
        test_hold();
        test_bounce();
        test_overrun();
        test_read_on_latch();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
